// File: rtl/herring_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : herring_pkg
//  Description : Shared clock FSM state type and default chip-select windows
//                for the herring clock generator / bus decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package herring_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        HIGH    = 2'd1,
        STRETCH = 2'd2
    } clk_state_t;

    // Windows over the 6 upper address bits: ACIA1 at 0x8000, VIA1 at 0x8400
    localparam logic [5:0] C_ACIA1_MATCH = 6'b100000;
    localparam logic [5:0] C_ACIA1_MASK  = 6'b111111;
    localparam logic [5:0] C_VIA1_MATCH  = 6'b100001;
    localparam logic [5:0] C_VIA1_MASK   = 6'b111111;

endpackage
`default_nettype wire

// File: rtl/herring_addr_match.sv
`default_nettype none
// ============================================================================
//  Module      : herring_addr_match
//  Description : NUM_CS mask/match address windows with lowest-index priority;
//                returns a one-hot select and the winning window's wait count.
//  Revision    : 1.0 - initial release
// ============================================================================
module herring_addr_match #(
    parameter int                           NUM_CS   = 8,
    parameter int                           ADDR_W   = 6,
    parameter int                           WAIT_W   = 3,
    parameter logic [NUM_CS*ADDR_W-1:0]     CS_MATCH = '0,
    parameter logic [NUM_CS*ADDR_W-1:0]     CS_MASK  = '0,
    parameter logic [NUM_CS*WAIT_W-1:0]     CS_WAIT  = '0
) (
    input  logic [ADDR_W-1:0]   i_address,
    output logic [NUM_CS-1:0]   o_select,
    output logic [WAIT_W-1:0]   o_wait
);

    logic [NUM_CS-1:0] w_hit;

    // An all-zero mask would otherwise match every address, so it disables the window
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_win
        assign w_hit[gi] = (CS_MASK[gi*ADDR_W +: ADDR_W] != '0) &&
                           (((i_address ^ CS_MATCH[gi*ADDR_W +: ADDR_W]) &
                             CS_MASK[gi*ADDR_W +: ADDR_W]) == '0);
    end

    always_comb begin
        o_select = '0;
        o_wait   = '0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_select    = '0;
                o_select[i] = 1'b1;
                o_wait      = CS_WAIT[i*WAIT_W +: WAIT_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/herring_clkgen_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : herring_clkgen_decoder
//  Description : 6502 clock generator with run-time divider and per-window
//                wait-state stretching, plus active-low chip-select decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module herring_clkgen_decoder
    import herring_pkg::*;
#(
    parameter int                           NUM_CS       = 8,
    parameter int                           ADDR_W       = 6,
    parameter int                           HALF_W       = 24,
    parameter int unsigned                  DEFAULT_HALF = 262143,
    parameter int                           WAIT_W       = 3,
    parameter logic [NUM_CS*ADDR_W-1:0]     CS_MATCH     = '0,
    parameter logic [NUM_CS*ADDR_W-1:0]     CS_MASK      = '0,
    parameter logic [NUM_CS*WAIT_W-1:0]     CS_WAIT      = '0
) (
    input  logic                clk_src,
    input  logic                reset_n,
    input  logic [HALF_W-1:0]   half_sel,
    input  logic [ADDR_W-1:0]   address,
    input  logic                rw,
    input  logic                cpu_clk_out,
    output logic                cpu_clk_in,
    output logic [NUM_CS-1:0]   decoder,
    output logic                ram_we_n,
    output logic                wait_active
);

    clk_state_t         r_state;
    logic [HALF_W-1:0]  r_cnt;
    logic [HALF_W-1:0]  r_half_q;
    logic [WAIT_W-1:0]  r_wait_q;
    logic               r_clk;
    logic               r_wait_active;

    logic [NUM_CS-1:0]  w_select;
    logic [WAIT_W-1:0]  w_win_wait;
    logic               w_phase_end;

    herring_addr_match #(
        .NUM_CS   (NUM_CS),
        .ADDR_W   (ADDR_W),
        .WAIT_W   (WAIT_W),
        .CS_MATCH (CS_MATCH),
        .CS_MASK  (CS_MASK),
        .CS_WAIT  (CS_WAIT)
    ) u_addr_match (
        .i_address (address),
        .o_select  (w_select),
        .o_wait    (w_win_wait)
    );

    assign w_phase_end = (r_cnt == r_half_q);

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= LOW;
            r_cnt         <= '0;
            r_half_q      <= HALF_W'(DEFAULT_HALF);
            r_wait_q      <= '0;
            r_clk         <= 1'b0;
            r_wait_active <= 1'b0;
        end else begin
            r_cnt <= w_phase_end ? '0 : r_cnt + 1'b1;
            case (r_state)
                LOW: begin
                    if (w_phase_end) begin
                        r_state  <= HIGH;
                        r_clk    <= 1'b1;
                        r_wait_q <= w_win_wait;
                    end
                end
                HIGH: begin
                    if (w_phase_end) begin
                        if (r_wait_q != '0) begin
                            r_state       <= STRETCH;
                            r_wait_active <= 1'b1;
                        end else begin
                            r_state  <= LOW;
                            r_clk    <= 1'b0;
                            r_half_q <= half_sel;
                        end
                    end
                end
                STRETCH: begin
                    // One full half-period consumed per wait state
                    if (w_phase_end) begin
                        r_wait_q <= r_wait_q - 1'b1;
                        if (r_wait_q <= WAIT_W'(1)) begin
                            r_state       <= LOW;
                            r_clk         <= 1'b0;
                            r_wait_active <= 1'b0;
                            r_half_q      <= half_sel;
                        end
                    end
                end
                default: begin
                    r_state       <= LOW;
                    r_clk         <= 1'b0;
                    r_wait_active <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_clk_in  = r_clk;
    assign wait_active = r_wait_active;
    assign decoder     = reset_n ? ~w_select : '1;
    assign ram_we_n    = reset_n ? ~(cpu_clk_out & ~rw) : 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_herring_clkgen_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_herring_clkgen_decoder
//  Description : Directed and randomized bench for herring_clkgen_decoder
//                against a period-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_herring_clkgen_decoder;

    localparam int C_NUM_CS = 8;
    localparam int C_ADDR_W = 6;
    localparam int C_WAIT_W = 3;
    localparam int C_HALF_W = 24;
    localparam int C_DEF    = 3;

    // Windows 7..0 (MSB first): 0=00xxxx w0, 2=100000 w1, 5=100001 w2,
    // 6=10000x w3 (overlaps 2 and 5), 7=11xxxx w4, 1/3/4 disabled
    localparam logic [47:0] C_MATCH = {6'b110000, 6'b100000, 6'b100001, 6'b000000,
                                       6'b000000, 6'b100000, 6'b000000, 6'b000000};
    localparam logic [47:0] C_MASK  = {6'b110000, 6'b111110, 6'b111111, 6'b000000,
                                       6'b000000, 6'b111111, 6'b000000, 6'b110000};
    localparam logic [23:0] C_WAIT  = {3'd4, 3'd3, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};

    logic                clk_src = 1'b0;
    logic                reset_n;
    logic [C_HALF_W-1:0] half_sel;
    logic [C_ADDR_W-1:0] address;
    logic                rw;
    logic                cpu_clk_out;
    logic                cpu_clk_in;
    logic [C_NUM_CS-1:0] decoder;
    logic                ram_we_n;
    logic                wait_active;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc;
    int n_hi;
    int n_wa;

    // Reference model: current level, cycles left in it, divider, cycles since rise
    logic m_level;
    int   m_rem;
    int   m_half;
    int   m_hi;

    herring_clkgen_decoder #(
        .NUM_CS       (C_NUM_CS),
        .ADDR_W       (C_ADDR_W),
        .HALF_W       (C_HALF_W),
        .DEFAULT_HALF (C_DEF),
        .WAIT_W       (C_WAIT_W),
        .CS_MATCH     (C_MATCH),
        .CS_MASK      (C_MASK),
        .CS_WAIT      (C_WAIT)
    ) dut (
        .clk_src     (clk_src),
        .reset_n     (reset_n),
        .half_sel    (half_sel),
        .address     (address),
        .rw          (rw),
        .cpu_clk_out (cpu_clk_out),
        .cpu_clk_in  (cpu_clk_in),
        .decoder     (decoder),
        .ram_we_n    (ram_we_n),
        .wait_active (wait_active)
    );

    always #10 clk_src = ~clk_src;

    function automatic int win_idx(input logic [5:0] a);
        for (int i = 0; i < C_NUM_CS; i++) begin
            if (C_MASK[i*6 +: 6] != 6'd0 && ((a ^ C_MATCH[i*6 +: 6]) & C_MASK[i*6 +: 6]) == 6'd0)
                return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_dec(input logic [5:0] a);
        int idx;
        idx = win_idx(a);
        return (idx < 0) ? 8'hFF : ~(8'd1 << idx);
    endfunction

    function automatic int wait_of(input logic [5:0] a);
        int idx;
        idx = win_idx(a);
        return (idx < 0) ? 0 : int'(C_WAIT[idx*3 +: 3]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = 1'b0;
        m_half  = C_DEF;
        m_rem   = C_DEF + 1;
        m_hi    = 0;
        cyc     = 0;
    endtask

    // Advance one clk_src edge, update the model, then check all outputs
    task automatic step();
        @(posedge clk_src);
        cyc++;
        m_rem--;
        if (m_level) m_hi++;
        if (m_rem == 0) begin
            if (!m_level) begin
                m_level = 1'b1;
                m_hi    = 0;
                m_rem   = (1 + wait_of(address)) * (m_half + 1);
            end else begin
                m_level = 1'b0;
                m_half  = int'(half_sel);
                m_rem   = m_half + 1;
            end
        end
        #1;
        check("cpu_clk_in", {31'd0, cpu_clk_in}, {31'd0, m_level});
        check("wait_active", {31'd0, wait_active},
              {31'd0, m_level && (m_hi >= m_half + 1)});
        check("decoder", {24'd0, decoder}, {24'd0, exp_dec(address)});
        check("ram_we_n", {31'd0, ram_we_n}, {31'd0, ~(cpu_clk_out & ~rw)});
    endtask

    task automatic wait_level(input logic v, input int budget);
        for (int k = 0; k < budget && cpu_clk_in !== v; k++) step();
        check("wait_level", {31'd0, cpu_clk_in}, {31'd0, v});
    endtask

    task automatic measure_high();
        n_hi = 0;
        n_wa = 0;
        while (cpu_clk_in === 1'b1 && n_hi < 100) begin
            step();
            n_hi++;
            if (wait_active === 1'b1) n_wa++;
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        half_sel    = 24'd3;
        address     = 6'b100000;
        rw          = 1'b0;
        cpu_clk_out = 1'b1;
        repeat (2) @(negedge clk_src);
        check("rst_clk", {31'd0, cpu_clk_in}, 32'd0);
        check("rst_wait", {31'd0, wait_active}, 32'd0);
        check("rst_dec", {24'd0, decoder}, 32'hFF);
        check("rst_we", {31'd0, ram_we_n}, 32'd1);

        // Divider change mid-HIGH completes the current period first
        address     = 6'b010101;
        cpu_clk_out = 1'b0;
        reset_n     = 1'b1;
        model_reset();
        wait_level(1'b1, 50);
        check("first_rise", cyc, 32'd4);
        step();
        step();
        half_sel = 24'd1;
        wait_level(1'b0, 50);
        check("fall_8", cyc, 32'd8);
        wait_level(1'b1, 50);
        check("rise_10", cyc, 32'd10);
        wait_level(1'b0, 50);
        check("fall_12", cyc, 32'd12);
        wait_level(1'b1, 50);
        check("rise_14", cyc, 32'd14);

        // Overlap of windows 2 and 6: window 2 and its wait of 1
        address = 6'b100000;
        #1;
        check("overlap_dec", {24'd0, decoder}, 32'hFB);
        wait_level(1'b0, 50);
        wait_level(1'b1, 50);
        measure_high();
        check("overlap_high", n_hi, 32'd4);
        check("overlap_wa", n_wa, 32'd2);

        // VIA window, half 3, two wait states
        half_sel = 24'd3;
        address  = 6'b100001;
        wait_level(1'b0, 50);
        wait_level(1'b1, 50);
        wait_level(1'b0, 50);
        wait_level(1'b1, 50);
        check("via_dec", {24'd0, decoder}, 32'hDF);
        measure_high();
        check("via_high", n_hi, 32'd12);
        check("via_wa", n_wa, 32'd8);

        // Write strobe combinations
        cpu_clk_out = 1'b1; rw = 1'b0; #1;
        check("we_write", {31'd0, ram_we_n}, 32'd0);
        rw = 1'b1; #1;
        check("we_read", {31'd0, ram_we_n}, 32'd1);
        cpu_clk_out = 1'b0; rw = 1'b0; #1;
        check("we_phi_low", {31'd0, ram_we_n}, 32'd1);

        // Asynchronous reset inside STRETCH
        for (int k = 0; k < 100 && wait_active !== 1'b1; k++) step();
        check("reach_stretch", {31'd0, wait_active}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_clk", {31'd0, cpu_clk_in}, 32'd0);
        check("arst_wait", {31'd0, wait_active}, 32'd0);
        check("arst_dec", {24'd0, decoder}, 32'hFF);
        half_sel = 24'd1;
        repeat (2) @(negedge clk_src);
        reset_n = 1'b1;
        model_reset();
        wait_level(1'b1, 50);
        check("arst_rise", cyc, 32'd4);
        measure_high();
        check("arst_high", n_hi, 32'd12);

        // Randomized traffic checked cycle by cycle against the model
        for (int k = 0; k < 800; k++) begin
            case ($urandom_range(0, 4))
                0: address = 6'b100000;
                1: address = 6'b100001;
                2: address = 6'($urandom_range(0, 15));
                3: address = 6'b110000 | 6'($urandom_range(0, 15));
                default: address = 6'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 15) == 0) half_sel = 24'($urandom_range(0, 3));
            rw          = 1'($urandom_range(0, 1));
            cpu_clk_out = 1'($urandom_range(0, 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
